// File: rtl/pipeline_step_ctrl_pkg.sv
// Shared constants for the pipeline execution controller and the debug unit
// that issues its commands.
package pipeline_step_ctrl_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h01;
  localparam logic [7:0] CMD_STEP  = 8'h02;
  localparam logic [7:0] CMD_STOP  = 8'h03;
  localparam logic [7:0] CMD_CLEAR = 8'h04;

  localparam int DRAIN_CYCLES_DEFAULT = 4;

  localparam int         STATE_W    = 3;
  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_RUN    = 3'd1;
  localparam logic [2:0] ENC_STEP   = 3'd2;
  localparam logic [2:0] ENC_DRAIN  = 3'd3;
  localparam logic [2:0] ENC_HALTED = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ENC_IDLE,
    S_RUN    = ENC_RUN,
    S_STEP   = ENC_STEP,
    S_DRAIN  = ENC_DRAIN,
    S_HALTED = ENC_HALTED
  } state_e;

endpackage

// File: rtl/pipeline_step_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_en && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Run/step/stop controller producing the shared pipeline-latch enable, with
// HALT drain sequencing and an enabled-cycle counter for the debug unit.
module pipeline_step_ctrl
  import pipeline_step_ctrl_pkg::*;
#(
  parameter int BUS_DATA     = 8,
  parameter int CYCLE_WIDTH  = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [BUS_DATA-1:0]    i_cmd_data,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_halt_detected,
  output logic                   o_enable,
  output logic                   o_halted,
  output logic                   o_busy,
  output logic [CYCLE_WIDTH-1:0] o_cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_e               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;

  logic cmd_accept;
  logic acc_run, acc_step, acc_stop, acc_clear;

  assign cmd_accept = i_cmd_valid & o_cmd_ready;
  assign acc_run    = cmd_accept & (i_cmd_data == BUS_DATA'(CMD_RUN));
  assign acc_step   = cmd_accept & (i_cmd_data == BUS_DATA'(CMD_STEP));
  assign acc_stop   = cmd_accept & (i_cmd_data == BUS_DATA'(CMD_STOP));
  assign acc_clear  = cmd_accept & (i_cmd_data == BUS_DATA'(CMD_CLEAR));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Halt outranks STOP in RUN: the STOP is consumed but the pipeline still drains.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (acc_run) begin
          state_d = S_RUN;
        end else if (acc_step) begin
          state_d = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        if (i_halt_detected) begin
          state_d = (DRAIN_CYCLES > 0) ? S_DRAIN : S_HALTED;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end else if (state_q == S_STEP || acc_stop) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_q <= DRAIN_W'(1)) begin
          state_d = S_HALTED;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_HALTED: state_d = S_HALTED;
      default: begin
        state_d = S_IDLE;
        drain_d = '0;
      end
    endcase
  end

  always_comb begin
    o_enable    = 1'b0;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b0;
    o_halted    = 1'b0;
    case (state_q)
      S_IDLE:   o_cmd_ready = 1'b1;
      S_RUN: begin
        o_enable    = 1'b1;
        o_cmd_ready = 1'b1;
        o_busy      = 1'b1;
      end
      S_STEP, S_DRAIN: begin
        o_enable = 1'b1;
        o_busy   = 1'b1;
      end
      S_HALTED: begin
        o_cmd_ready = 1'b1;
        o_halted    = 1'b1;
      end
      default: o_cmd_ready = 1'b0;
    endcase
  end

  sat_counter #(
    .WIDTH (CYCLE_WIDTH)
  ) u_cycle_counter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (acc_clear),
    .i_en    (o_enable),
    .o_count (o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed and randomized bench for pipeline_step_ctrl against a cycle-level
// behavioural model of the run/step/drain rules.
module tb_pipeline_step_ctrl;

  localparam int CW    = 4;
  localparam int DRAIN = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk;
  logic          i_reset;
  logic [7:0]    i_cmd_data;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_halt_detected;
  logic          o_enable;
  logic          o_halted;
  logic          o_busy;
  logic [CW-1:0] o_cycle_count;

  int n_checks;
  int n_errors;

  // Model: independent flags for "running", "one step pending", drain cycles left, done.
  bit m_run;
  bit m_step;
  int m_drain_left;
  bit m_done;
  int m_count;

  pipeline_step_ctrl #(
    .BUS_DATA     (8),
    .CYCLE_WIDTH  (CW),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_cmd_data      (i_cmd_data),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_halt_detected (i_halt_detected),
    .o_enable        (o_enable),
    .o_halted        (o_halted),
    .o_busy          (o_busy),
    .o_cycle_count   (o_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_enabled();
    return m_run || m_step || (m_drain_left > 0);
  endfunction

  function automatic bit m_ready();
    return !m_step && (m_drain_left == 0);
  endfunction

  task automatic model_reset();
    m_run = 0; m_step = 0; m_drain_left = 0; m_done = 0; m_count = 0;
  endtask

  task automatic model_edge();
    bit en, acc;
    en  = m_enabled();
    acc = i_cmd_valid && m_ready();
    if (acc && i_cmd_data == 8'h04) m_count = 0;
    else if (en) m_count = (m_count >= SAT) ? SAT : m_count + 1;
    if ((m_run || m_step) && i_halt_detected) begin
      m_run = 0; m_step = 0; m_drain_left = DRAIN;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_done = 1;
    end else if (m_step) begin
      m_step = 0;
    end else if (m_run) begin
      if (acc && i_cmd_data == 8'h03) m_run = 0;
    end else if (!m_done) begin
      if (acc && i_cmd_data == 8'h01) m_run = 1;
      else if (acc && i_cmd_data == 8'h02) m_step = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".enable"}, 32'(o_enable),      32'(m_enabled()));
    check({tag, ".ready"},  32'(o_cmd_ready),   32'(m_ready()));
    check({tag, ".busy"},   32'(o_busy),        32'(m_enabled()));
    check({tag, ".halted"}, 32'(o_halted),      32'(m_done));
    check({tag, ".count"},  32'(o_cycle_count), 32'(m_count));
  endtask

  task automatic tick(input string tag, input logic [7:0] cmd, input logic vld, input logic halt);
    i_cmd_data = cmd; i_cmd_valid = vld; i_halt_detected = halt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    i_cmd_valid = 1'b0; i_halt_detected = 1'b0; i_cmd_data = 8'h00;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    i_reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    i_reset = 1'b0;
    check_all({tag, ".rel"});
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    i_reset = 1'b1; i_cmd_data = 8'h00; i_cmd_valid = 1'b0; i_halt_detected = 1'b0;
    model_reset();
    #3;
    check_all("por");
    @(negedge clk);
    do_reset("rst0");

    // RUN for ten enabled cycles, STOP accepted on the tenth.
    tick("run_cmd", 8'h01, 1, 0);
    for (int i = 0; i < 9; i++) tick("run", 8'h00, 0, 0);
    tick("stop_cmd", 8'h03, 1, 0);
    check("run10.count", 32'(o_cycle_count), 32'd10);
    check("run10.ready", 32'(o_cmd_ready), 32'd1);
    tick("idle", 8'h00, 0, 0);

    // Three STEPs with valid held high.
    tick("clr", 8'h04, 1, 0);
    for (int i = 0; i < 6; i++) tick("steps", 8'h02, 1, 0);
    check("steps.count", 32'(o_cycle_count), 32'd3);
    tick("idle2", 8'h00, 0, 0);

    // HALT on the fifth enabled cycle, then drain.
    tick("clr2", 8'h04, 1, 0);
    tick("run2", 8'h01, 1, 0);
    for (int i = 0; i < 4; i++) tick("run2", 8'h00, 0, 0);
    tick("halt", 8'h00, 0, 1);
    for (int i = 0; i < DRAIN; i++) tick("drain", 8'h00, 0, 0);
    check("halt.halted", 32'(o_halted), 32'd1);
    check("halt.count", 32'(o_cycle_count), 32'd9);
    tick("halted_run", 8'h01, 1, 0);
    tick("halted_step", 8'h02, 1, 0);
    tick("halted_stop", 8'h03, 1, 0);
    do_reset("rst1");

    // STOP and HALT together in RUN.
    tick("run3", 8'h01, 1, 0);
    tick("run3", 8'h00, 0, 0);
    tick("stop_halt", 8'h03, 1, 1);
    check("stop_halt.enable", 32'(o_enable), 32'd1);
    for (int i = 0; i < DRAIN; i++) tick("drain3", 8'h00, 0, 0);
    check("stop_halt.halted", 32'(o_halted), 32'd1);
    do_reset("rst2");

    // Saturation and CLEAR while running.
    tick("run4", 8'h01, 1, 0);
    for (int i = 0; i < 18; i++) tick("sat", 8'h00, 0, 0);
    check("sat.count", 32'(o_cycle_count), 32'(SAT));
    tick("clr_run", 8'h04, 1, 0);
    check("clr_run.count", 32'(o_cycle_count), 32'd0);
    tick("resume", 8'h00, 0, 0);
    check("resume.count", 32'(o_cycle_count), 32'd1);

    // Asynchronous reset in the middle of a drain.
    tick("halt5", 8'h00, 0, 1);
    tick("drain5", 8'h00, 0, 0);
    #2;
    do_reset("rst_drain");

    // Randomized commands, halts and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] cmd;
      cmd = 8'($urandom_range(0, 6));
      if (cmd == 8'h06) cmd = 8'($urandom);
      if ((m_done && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0)
        do_reset("rnd_rst");
      else
        tick("rnd", cmd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 11) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_step_ctrl.md
# pipeline_step_ctrl

Execution controller for the MIPS pipeline. Generates the single enable that drives `i_valid` on every inter-stage pipeline latch and the PC register, so the processor can run continuously, advance one clock per command, or stop. Sits directly upstream of the pipeline latches, between the debug/command interface and the datapath. Also detects program end, drains in-flight instructions, and keeps an enabled-cycle count for the debug unit.

## Interface
Parameters:
- `BUS_DATA`, 8, command code width
- `CYCLE_WIDTH`, 32, cycle counter width
- `DRAIN_CYCLES`, 4, enabled cycles after HALT detection (ID→EX→MEM→WB→retire)

Ports:
- `i_clock`  in  1  system clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_cmd_data`  in  BUS_DATA  command code
- `i_cmd_valid`  in  1  command present
- `o_cmd_ready`  out  1  controller accepts a command this cycle
- `i_halt_detected`  in  1  HALT opcode decoded in ID this cycle
- `o_enable`  out  1  drives `i_valid` of all pipeline latches and PC
- `o_halted`  out  1  program finished, pipeline drained
- `o_busy`  out  1  high in RUN, STEP, DRAIN
- `o_cycle_count`  out  CYCLE_WIDTH  number of cycles with `o_enable` high

## Operation
- Command codes: 0x01 RUN, 0x02 STEP, 0x03 STOP, 0x04 CLEAR. Any other code is accepted and discarded.
- A command is accepted on a rising edge with `i_cmd_valid & o_cmd_ready`.
- States:
  - IDLE: enable=0, ready=1. RUN→RUN; STEP→STEP; CLEAR zeroes the counter; STOP has no effect.
  - RUN: enable=1, ready=1. STOP→IDLE; CLEAR zeroes the counter; RUN and STEP have no effect.
  - STEP: enable=1 for exactly one cycle, ready=0, then →IDLE.
  - DRAIN: enable=1, ready=0. Drain counter loads `DRAIN_CYCLES` on entry. After `DRAIN_CYCLES` enabled cycles →HALTED. `i_halt_detected` is ignored in this state.
  - HALTED: enable=0, ready=1, `o_halted`=1. Only CLEAR has an effect; all other commands are discarded. State is sticky until reset.
- `i_halt_detected` sampled high in RUN or STEP → DRAIN. The HALT cycle itself counts as enabled.
- Simultaneous events:
  - Halt plus STOP in RUN: halt wins; STOP is consumed and dropped.
  - CLEAR plus increment in the same cycle: counter becomes 0.
- Cycle counter increments on every edge where `o_enable`=1 and saturates at all-ones.
- `o_enable`, `o_busy`, `o_halted` and `o_cmd_ready` are decoded from registered state only. No combinational path from any input.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `o_enable`=0, `o_cmd_ready`=1, `o_busy`=0, `o_halted`=0, `o_cycle_count`=0, drain counter=0.
- Command latency: a command accepted at edge N changes `o_enable` in the cycle after edge N.
  - RUN at edge N: enable high from cycle N+1.
  - STOP at edge N: enable low from cycle N+1.
- STEP: exactly one enabled cycle, then IDLE. Back-to-back STEPs give one enable pulse per accepted command, with at least one idle cycle between pulses.
- DRAIN: enable is continuous for `DRAIN_CYCLES` cycles following the halt cycle. `o_halted` rises in the next cycle.
- Reset mid-RUN or mid-DRAIN: enable drops immediately (asynchronously); counter clears.

## Structure
- Shared package/header holds:
  - command code constants (CMD_RUN, CMD_STEP, CMD_STOP, CMD_CLEAR)
  - state encoding localparams
  - default `DRAIN_CYCLES`
  
  The debug unit uses the same constants.
- One sub-module: `sat_counter` (width parameter, enable, synchronous clear with priority, saturation), instantiated for the cycle count.
- The drain counter is a `$clog2(DRAIN_CYCLES+1)`-bit down-counter inside the FSM.

## Test plan
- Reset, then RUN for 10 cycles, then STOP → `o_enable` high exactly 10 cycles, `o_cycle_count`=10, state IDLE, `o_cmd_ready`=1.
- Three STEP commands with `i_cmd_valid` held high → three single-cycle enable pulses, `o_cycle_count`=3, `o_cmd_ready` low during each pulse.
- RUN, then `i_halt_detected` pulsed on the 5th enabled cycle → 4 further enabled cycles; `o_halted`=1 with `o_cycle_count`=9; later RUN and STEP commands are accepted and ignored.
- In RUN, STOP and `i_halt_detected` in the same cycle → DRAIN taken, `o_halted` asserts, no early stop.
- Counter at all-ones minus 1 with `CYCLE_WIDTH`=4, running → saturates at 15. CLEAR while RUN → counter 0 that cycle, then resumes from 1.
- Assert `i_reset` mid-DRAIN → all outputs return to reset values without waiting for a clock edge.
